// File: rtl/sort_frame_stat_pkg.sv
// Shared widths and state encoding for the sorter-output frame statistics block.
package sort_frame_stat_pkg;

  localparam int unsigned DW        = 9;
  localparam int unsigned FRAME_LEN = 6;
  localparam int unsigned CW        = 3;
  localparam int unsigned SW        = 12;

  typedef enum logic {
    StIdle = 1'b0,
    StAcc  = 1'b1
  } state_e;

endpackage

// File: rtl/sort_frame_stat_if.sv
// Frame word input and statistics result bus of sort_frame_stat.
interface sort_frame_stat_if;
  import sort_frame_stat_pkg::*;

  logic          in_valid;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic [SW-1:0] sum_out;
  logic [DW-1:0] max_out;
  logic [DW-1:0] min_out;
  logic [DW-1:0] first_out;
  logic [DW-1:0] last_out;
  logic          desc_ok;
  logic          frame_err;
  logic [7:0]    frame_cnt;

  modport master (
    output in_valid, data_in,
    input  out_valid, sum_out, max_out, min_out, first_out, last_out, desc_ok, frame_err,
           frame_cnt
  );

  modport slave (
    input  in_valid, data_in,
    output out_valid, sum_out, max_out, min_out, first_out, last_out, desc_ok, frame_err,
           frame_cnt
  );
endinterface

// File: rtl/sort_frame_stat_stat_update.sv
// Combinational next-value of the running sum/max/min/descending flag for one new word.
module sort_frame_stat_stat_update
  import sort_frame_stat_pkg::*;
(
  input  logic [SW-1:0] sum_acc,
  input  logic [DW-1:0] max_acc,
  input  logic [DW-1:0] min_acc,
  input  logic [DW-1:0] prev,
  input  logic          desc_acc,
  input  logic [DW-1:0] data_in,
  output logic [SW-1:0] sum_nxt,
  output logic [DW-1:0] max_nxt,
  output logic [DW-1:0] min_nxt,
  output logic          desc_nxt
);

  assign sum_nxt  = sum_acc + SW'(data_in);
  assign max_nxt  = (data_in > max_acc) ? data_in : max_acc;
  assign min_nxt  = (data_in < min_acc) ? data_in : min_acc;
  assign desc_nxt = desc_acc & (prev >= data_in);

endmodule

// File: rtl/sort_frame_stat.sv
// Per-frame statistics over FRAME_LEN contiguous words; a gap mid-frame aborts with frame_err.
module sort_frame_stat
  import sort_frame_stat_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  sort_frame_stat_if.slave bus
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_acc_q, sum_acc_d;
  logic [DW-1:0] max_acc_q, max_acc_d, min_acc_q, min_acc_d;
  logic [DW-1:0] first_q, first_d, prev_q, prev_d;
  logic          desc_acc_q, desc_acc_d;

  logic          out_valid_q, out_valid_d, frame_err_q, frame_err_d;
  logic [SW-1:0] sum_out_q, sum_out_d;
  logic [DW-1:0] max_out_q, max_out_d, min_out_q, min_out_d;
  logic [DW-1:0] first_out_q, first_out_d, last_out_q, last_out_d;
  logic          desc_ok_q, desc_ok_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic          idle;
  logic [SW-1:0] sum_nxt;
  logic [DW-1:0] max_nxt, min_nxt;
  logic          desc_nxt;

  // In IDLE the updater sees neutral seeds so the same path loads word 0.
  assign idle = (state_q == StIdle);

  sort_frame_stat_stat_update u_stat_update (
    .sum_acc  (idle ? '0 : sum_acc_q),
    .max_acc  (idle ? '0 : max_acc_q),
    .min_acc  (idle ? '1 : min_acc_q),
    .prev     (idle ? '1 : prev_q),
    .desc_acc (idle ? 1'b1 : desc_acc_q),
    .data_in  (bus.data_in),
    .sum_nxt  (sum_nxt),
    .max_nxt  (max_nxt),
    .min_nxt  (min_nxt),
    .desc_nxt (desc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_acc_d   = sum_acc_q;
    max_acc_d   = max_acc_q;
    min_acc_d   = min_acc_q;
    desc_acc_d  = desc_acc_q;
    first_d     = first_q;
    prev_d      = prev_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    sum_out_d   = sum_out_q;
    max_out_d   = max_out_q;
    min_out_d   = min_out_q;
    first_out_d = first_out_q;
    last_out_d  = last_out_q;
    desc_ok_d   = desc_ok_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sum_acc_d  = sum_nxt;
          max_acc_d  = max_nxt;
          min_acc_d  = min_nxt;
          desc_acc_d = desc_nxt;
          first_d    = bus.data_in;
          prev_d     = bus.data_in;
          cnt_d      = CW'(1);
          state_d    = StAcc;
        end
      end
      StAcc: begin
        if (!bus.in_valid) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = StIdle;
        end else if (cnt_q == CW'(FRAME_LEN - 1)) begin
          sum_out_d   = sum_nxt;
          max_out_d   = max_nxt;
          min_out_d   = min_nxt;
          desc_ok_d   = desc_nxt;
          first_out_d = first_q;
          last_out_d  = bus.data_in;
          out_valid_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          cnt_d       = '0;
          state_d     = StIdle;
        end else begin
          sum_acc_d  = sum_nxt;
          max_acc_d  = max_nxt;
          min_acc_d  = min_nxt;
          desc_acc_d = desc_nxt;
          prev_d     = bus.data_in;
          cnt_d      = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sum_acc_q   <= '0;
      max_acc_q   <= '0;
      min_acc_q   <= '0;
      desc_acc_q  <= 1'b0;
      first_q     <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      sum_out_q   <= '0;
      max_out_q   <= '0;
      min_out_q   <= '0;
      first_out_q <= '0;
      last_out_q  <= '0;
      desc_ok_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_acc_q   <= sum_acc_d;
      max_acc_q   <= max_acc_d;
      min_acc_q   <= min_acc_d;
      desc_acc_q  <= desc_acc_d;
      first_q     <= first_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      sum_out_q   <= sum_out_d;
      max_out_q   <= max_out_d;
      min_out_q   <= min_out_d;
      first_out_q <= first_out_d;
      last_out_q  <= last_out_d;
      desc_ok_q   <= desc_ok_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.sum_out   = sum_out_q;
  assign bus.max_out   = max_out_q;
  assign bus.min_out   = min_out_q;
  assign bus.first_out = first_out_q;
  assign bus.last_out  = last_out_q;
  assign bus.desc_ok   = desc_ok_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sort_frame_stat.sv
// Directed bench for sort_frame_stat: inputs change on the falling edge, outputs checked there too.
module tb_sort_frame_stat;
  import sort_frame_stat_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sort_frame_stat_if bus ();

  sort_frame_stat u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [DW-1:0] w);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = w;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
  endtask

  task automatic frame(input logic [DW-1:0] w0, w1, w2, w3, w4, w5);
    word(w0); word(w1); word(w2); word(w3); word(w4); word(w5);
  endtask

  task automatic check_stats(input string tag, input int sum, input int mx, input int mn,
                             input int first, input int last, input int desc, input int cnt);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, ".sum"},       32'(bus.sum_out),   sum);
    check({tag, ".max"},       32'(bus.max_out),   mx);
    check({tag, ".min"},       32'(bus.min_out),   mn);
    check({tag, ".first"},     32'(bus.first_out), first);
    check({tag, ".last"},      32'(bus.last_out),  last);
    check({tag, ".desc_ok"},   32'(bus.desc_ok),   desc);
    check({tag, ".frame_cnt"}, 32'(bus.frame_cnt), cnt);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.frame_err", 32'(bus.frame_err), 32'd0);
    check("rst.frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("rst.desc_ok",   32'(bus.desc_ok),   32'd0);
    check("rst.sum",       32'(bus.sum_out),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Strictly descending frame
    frame(500, 400, 300, 200, 100, 0);
    idle();
    check_stats("f1", 1500, 500, 0, 500, 0, 1, 1);
    idle();
    check("f1.pulse_end", 32'(bus.out_valid), 32'd0);
    check("f1.hold_sum",  32'(bus.sum_out),   32'd1500);

    frame(3, 9, 1, 511, 7, 7);
    idle();
    check_stats("f2", 538, 511, 1, 3, 7, 0, 2);

    // Back-to-back: 12 consecutive valid cycles
    idle();
    for (int i = 0; i < 6; i++) word(511);
    word(0);
    check_stats("b2b1", 3066, 511, 511, 511, 511, 1, 3);
    for (int i = 0; i < 5; i++) begin
      word(0);
      check("b2b.gap_no_valid", 32'(bus.out_valid), 32'd0);
    end
    idle();
    check_stats("b2b2", 0, 0, 0, 0, 0, 1, 4);

    // Truncated frame: 4 words then a gap
    idle();
    word(10); word(20); word(30); word(40);
    idle();
    check("trunc.no_err_yet", 32'(bus.frame_err), 32'd0);
    idle();
    check("trunc.frame_err", 32'(bus.frame_err), 32'd1);
    check("trunc.out_valid", 32'(bus.out_valid), 32'd0);
    check("trunc.frame_cnt", 32'(bus.frame_cnt), 32'd4);
    check("trunc.hold_sum",  32'(bus.sum_out),   32'd0);
    check("trunc.hold_desc", 32'(bus.desc_ok),   32'd1);
    idle();
    check("trunc.err_pulse", 32'(bus.frame_err), 32'd0);
    frame(50, 40, 40, 30, 20, 10);
    idle();
    check_stats("after_trunc", 190, 50, 10, 50, 10, 1, 5);

    // Reset mid-frame
    idle();
    word(1); word(2); word(3);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst.frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("midrst.sum",       32'(bus.sum_out),   32'd0);
    check("midrst.max",       32'(bus.max_out),   32'd0);
    check("midrst.first",     32'(bus.first_out), 32'd0);
    check("midrst.desc_ok",   32'(bus.desc_ok),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("midrst.no_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.no_err",   32'(bus.frame_err), 32'd0);
    frame(7, 6, 5, 4, 3, 2);
    idle();
    check_stats("post_rst", 27, 7, 2, 7, 2, 1, 1);

    // Frame counter wrap: 254 more back-to-back frames reach 255, one more wraps to 0
    for (int f = 0; f < 254; f++) frame(1, 1, 1, 1, 1, 1);
    idle();
    check_stats("cnt255", 6, 1, 1, 1, 1, 1, 255);
    frame(2, 2, 2, 2, 2, 2);
    idle();
    check_stats("cnt_wrap", 12, 2, 2, 2, 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sort_frame_stat.md
Name: sort_frame_stat

Overview:
- Downstream consumer of the 6-word sorter output stream: accepts one frame of FRAME_LEN contiguous 9-bit words on in_valid/data_in.
- Produces per-frame statistics: sum, max, min, first/last word, a descending-order check flag and a running frame count.
- Detects truncated frames (in_valid gap mid-frame) and flags them instead of reporting.
- Sits directly on the sorter's out_valid/data_out bus; result is consumed by the lab's output checker/display logic.

Parameters:
- DW, 9, data word width.
- FRAME_LEN, 6, words per frame (>=2).
- CW, 3, sample counter width (clog2(FRAME_LEN+1)).
- SW, 12, sum width = DW + clog2(FRAME_LEN); 6*511 = 3066 fits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  data_in is a valid frame word this cycle.
- data_in  in  DW  frame word.
- out_valid  out  1  one-cycle pulse: statistics outputs valid.
- sum_out  out  SW  sum of frame words.
- max_out  out  DW  largest word.
- min_out  out  DW  smallest word.
- first_out  out  DW  word 0 of frame.
- last_out  out  DW  word FRAME_LEN-1.
- desc_ok  out  1  1 if frame is non-increasing (w[i] >= w[i+1] for all i).
- frame_err  out  1  one-cycle pulse: frame aborted by in_valid gap.
- frame_cnt  out  8  count of good frames, wraps 255->0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, sample count 0, all outputs 0 (out_valid=0, frame_err=0, frame_cnt=0, desc_ok=0), accumulators cleared.
- FSM states: IDLE, ACC.
- IDLE: in_valid=1 -> load sum=data_in, max=min=first=prev=data_in, desc flag=1, count=1, go ACC. in_valid=0 -> stay.
- ACC, in_valid=1: sum+=data_in (unsigned, zero-extended to SW, no overflow by construction); max/min update with unsigned compare; desc flag &= (prev >= data_in); prev<=data_in; count+=1.
- ACC, word FRAME_LEN accepted: on that edge register sum/max/min/first/last/desc_ok with final values including the current word; out_valid=1 next cycle only; frame_cnt+=1 on the same edge; count->0, go IDLE.
- Latency: out_valid asserted exactly 1 cycle after the edge capturing the last word.
- Back-to-back frames: in_valid high in the cycle out_valid is high is word 0 of the next frame (IDLE handles it); zero bubble required.
- ACC, in_valid=0 (gap before word FRAME_LEN): frame_err=1 next cycle for one cycle, partial data discarded, go IDLE. Stat outputs and frame_cnt keep last good frame values.
- Stat outputs hold between out_valid pulses; only sample on out_valid.
- Ties: equal neighbours keep desc_ok=1; max==min allowed.
- Reset mid-frame: immediate clear, partial frame lost, no out_valid/frame_err generated.
- out_valid and frame_err never high in the same cycle.

Decomposition:
- Shared package: DW, FRAME_LEN, SW, state encoding localparams (IDLE=1'b0, ACC=1'b1).
- One natural sub-module: stat_update (combinational next-value of sum/max/min/desc from current accumulators + data_in), instanced once, reused for the IDLE-load path by feeding neutral seed values.

Test Plan:
- Reset then frame 500,400,300,200,100,0 -> one cycle later out_valid=1, sum=1500, max=500, min=0, first=500, last=0, desc_ok=1, frame_cnt=1.
- Frame 3,9,1,511,7,7 -> sum=538, max=511, min=1, desc_ok=0, frame_cnt increments.
- Two frames back-to-back (12 consecutive in_valid cycles, all 511 then all 0) -> two out_valid pulses 6 cycles apart: sum=3066/max=511, then sum=0/min=0; all-equal frames give desc_ok=1.
- 4 words then in_valid=0 -> frame_err=1 for one cycle, no out_valid, outputs and frame_cnt unchanged; following full frame reports correctly.
- rst_n pulsed low after word 3 -> all outputs 0 immediately; next full frame reports frame_cnt=1.
- 256 good frames -> frame_cnt wraps to 0.
